// File: rtl/traffic_pkg.sv
// Shared phase encoding and default phase durations for the traffic light sequencer.
package traffic_pkg;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2,
      FLASH   = 2'd3
   } phase_e;

   localparam int DEF_NUM_DIR     = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_GREEN_T     = 20;
   localparam int DEF_PED_GREEN_T = 32;
   localparam int DEF_YELLOW_T    = 4;
   localparam int DEF_ALLRED_T    = 2;
   localparam int DEF_FLASH_T     = 8;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; done flags the final cycle of a phase.
module phase_timer #(
   parameter int CNT_W   = 16,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= CNT_W'(RST_VAL);
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/traffic_light_seq_ctrl.sv
// Round-robin N-approach traffic light sequencer with pedestrian-extended green and flashing-yellow mode.
// Moore lamp outputs decoded straight from registered state; inputs take effect the cycle after sampling.
module traffic_light_seq_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_DIR     = DEF_NUM_DIR,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GREEN_T     = DEF_GREEN_T,
   parameter int PED_GREEN_T = DEF_PED_GREEN_T,
   parameter int YELLOW_T    = DEF_YELLOW_T,
   parameter int ALLRED_T    = DEF_ALLRED_T,
   parameter int FLASH_T     = DEF_FLASH_T,
   parameter int DIR_W       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flash_mode,
   input  logic [NUM_DIR-1:0] ped_req,
   output logic [NUM_DIR-1:0] red,
   output logic [NUM_DIR-1:0] yellow,
   output logic [NUM_DIR-1:0] green,
   output logic [NUM_DIR-1:0] walk,
   output logic [DIR_W-1:0]   active_dir,
   output logic [1:0]         phase
);

   localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

   phase_e             phase_q, phase_nxt;
   logic [DIR_W-1:0]   dir_q, dir_nxt, dir_inc;
   logic [NUM_DIR-1:0] latch_q, latch_nxt;
   logic               grant_q, grant_nxt;
   logic               flash_on_q, flash_on_nxt;
   logic               load;
   logic [CNT_W-1:0]   load_val;
   logic               done;

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALLRED_T - 1)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_q    <= ALL_RED;
         dir_q      <= LAST_DIR;
         latch_q    <= '0;
         grant_q    <= 1'b0;
         flash_on_q <= 1'b0;
      end else begin
         phase_q    <= phase_nxt;
         dir_q      <= dir_nxt;
         latch_q    <= latch_nxt;
         grant_q    <= grant_nxt;
         flash_on_q <= flash_on_nxt;
      end
   end

   always_comb begin
      phase_nxt    = phase_q;
      dir_nxt      = dir_q;
      latch_nxt    = latch_q | ped_req;
      grant_nxt    = grant_q;
      flash_on_nxt = flash_on_q;
      load         = 1'b0;
      load_val     = '0;
      dir_inc      = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;

      if (phase_q != FLASH && flash_mode) begin
         phase_nxt    = FLASH;
         flash_on_nxt = 1'b1;
         load         = 1'b1;
         load_val     = CNT_W'(FLASH_T - 1);
      end else if (phase_q == FLASH) begin
         if (!flash_mode) begin
            // active_dir is kept so the round resumes with the following approach
            phase_nxt    = ALL_RED;
            flash_on_nxt = 1'b0;
            load         = 1'b1;
            load_val     = CNT_W'(ALLRED_T - 1);
         end else if (done) begin
            flash_on_nxt = ~flash_on_q;
            load         = 1'b1;
            load_val     = CNT_W'(FLASH_T - 1);
         end
      end else if (done) begin
         case (phase_q)
            ALL_RED: begin
               // the capture cycle consumes the request; later cycles re-arm the latch
               phase_nxt          = GREEN;
               dir_nxt            = dir_inc;
               grant_nxt          = latch_q[dir_inc] | ped_req[dir_inc];
               latch_nxt[dir_inc] = 1'b0;
               load               = 1'b1;
               load_val           = grant_nxt ? CNT_W'(PED_GREEN_T - 1) : CNT_W'(GREEN_T - 1);
            end
            GREEN: begin
               phase_nxt = YELLOW;
               load      = 1'b1;
               load_val  = CNT_W'(YELLOW_T - 1);
            end
            YELLOW: begin
               phase_nxt = ALL_RED;
               load      = 1'b1;
               load_val  = CNT_W'(ALLRED_T - 1);
            end
            default: begin
               phase_nxt = ALL_RED;
            end
         endcase
      end
   end

   always_comb begin
      red    = '1;
      yellow = '0;
      green  = '0;
      walk   = '0;
      case (phase_q)
         FLASH: begin
            red    = '0;
            yellow = {NUM_DIR{flash_on_q}};
         end
         GREEN: begin
            red[dir_q]   = 1'b0;
            green[dir_q] = 1'b1;
            walk[dir_q]  = grant_q;
         end
         YELLOW: begin
            red[dir_q]    = 1'b0;
            yellow[dir_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign active_dir = dir_q;
   assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_seq_ctrl.sv
// Scoreboard bench: stimulus queues hand-derived per-cycle lamp expectations, a negedge monitor pops and compares.
module tb_traffic_light_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flash_mode;
   logic [2:0] ped_req;
   logic [2:0] red, yellow, green, walk;
   logic [1:0] active_dir;
   logic [1:0] phase;

   typedef struct {
      logic [1:0] ph;
      logic [1:0] dir;
      logic [2:0] r, y, g, w;
      int         tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   inv_en = 1'b0;

   traffic_light_seq_ctrl #(
      .NUM_DIR     (3),
      .CNT_W       (16),
      .GREEN_T     (5),
      .PED_GREEN_T (8),
      .YELLOW_T    (2),
      .ALLRED_T    (1),
      .FLASH_T     (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flash_mode (flash_mode),
      .ped_req    (ped_req),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .walk       (walk),
      .active_dir (active_dir),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [1:0] ph, input int d, input logic [2:0] r,
                       input logic [2:0] y, input logic [2:0] g, input logic [2:0] w,
                       input int tag);
      exp_t e;
      e.ph  = ph;
      e.dir = 2'(d);
      e.r   = r;
      e.y   = y;
      e.g   = g;
      e.w   = w;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // green (gdur cycles), 2 yellow, 1 all-red for approach d
   task automatic round(input int d, input int gdur, input bit wk, input int tag);
      logic [2:0] oh;
      oh = 3'b001 << d;
      for (int i = 0; i < gdur; i++) push(2'd1, d, ~oh, 3'b000, oh, wk ? oh : 3'b000, tag);
      for (int i = 0; i < 2; i++)    push(2'd2, d, ~oh, oh, 3'b000, 3'b000, tag);
      push(2'd0, d, 3'b111, 3'b000, 3'b000, 3'b000, tag);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int k);
      while (cyc < k) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   n, nonred;
      bit   ok;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({phase, active_dir, red, yellow, green, walk} !== {e.ph, e.dir, e.r, e.y, e.g, e.w}) begin
            errors++;
            $display("FAIL seq tag=%0d t=%0t got ph=%0d dir=%0d r=%b y=%b g=%b w=%b required ph=%0d dir=%0d r=%b y=%b g=%b w=%b",
                     e.tag, $time, phase, active_dir, red, yellow, green, walk,
                     e.ph, e.dir, e.r, e.y, e.g, e.w);
         end
      end
      if (inv_en) begin
         ok     = 1'b1;
         nonred = 0;
         if (phase != 2'd3) begin
            for (int k = 0; k < 3; k++) begin
               n = int'(red[k]) + int'(yellow[k]) + int'(green[k]);
               if (n != 1) ok = 1'b0;
               if (!red[k]) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
         end else if (red != 3'b000 || green != 3'b000) begin
            ok = 1'b0;
         end
         if ((walk & ~green) != 3'b000) ok = 1'b0;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL invariant t=%0t got ph=%0d r=%b y=%b g=%b w=%b required one lamp per approach, at most one non-red, walk only with green",
                     $time, phase, red, yellow, green, walk);
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      flash_mode = 1'b0;
      ped_req    = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      cyc = 0;

      // reset release and plain round-robin (with a ped pulse for approach 1 at cycle 26)
      push(2'd0, 2, 3'b111, 3'b000, 3'b000, 3'b000, 1);
      reset_n = 1'b1;
      inv_en  = 1'b1;
      round(0, 5, 1'b0, 1);
      round(1, 5, 1'b0, 1);
      round(2, 5, 1'b0, 1);
      round(0, 5, 1'b0, 1);
      goto(26); ped_req = 3'b010;
      goto(27); ped_req = 3'b000;

      goto(33);
      round(1, 8, 1'b1, 2);
      round(2, 5, 1'b0, 2);
      round(0, 5, 1'b0, 2);
      round(1, 5, 1'b0, 2);

      // request held across approach 1 green entry
      goto(68);
      round(2, 5, 1'b0, 3);
      round(0, 5, 1'b0, 3);
      round(1, 8, 1'b1, 3);
      round(2, 5, 1'b0, 3);
      round(0, 5, 1'b0, 3);
      round(1, 8, 1'b1, 3);
      goto(83); ped_req = 3'b010;
      goto(87); ped_req = 3'b000;

      // flash mid-green of approach 1, then reset during yellow of approach 2
      goto(122);
      round(2, 5, 1'b0, 4);
      round(0, 5, 1'b0, 4);
      for (int i = 0; i < 3; i++) push(2'd1, 1, 3'b101, 3'b000, 3'b010, 3'b000, 4);
      for (int i = 0; i < 3; i++) push(2'd3, 1, 3'b000, 3'b111, 3'b000, 3'b000, 4);
      for (int i = 0; i < 3; i++) push(2'd3, 1, 3'b000, 3'b000, 3'b000, 3'b000, 4);
      for (int i = 0; i < 3; i++) push(2'd3, 1, 3'b000, 3'b111, 3'b000, 3'b000, 4);
      push(2'd0, 1, 3'b111, 3'b000, 3'b000, 3'b000, 4);
      for (int i = 0; i < 5; i++) push(2'd1, 2, 3'b011, 3'b000, 3'b100, 3'b000, 5);
      push(2'd2, 2, 3'b011, 3'b100, 3'b000, 3'b000, 5);
      push(2'd0, 2, 3'b111, 3'b000, 3'b000, 3'b000, 5);
      round(0, 5, 1'b0, 5);
      goto(140); flash_mode = 1'b1;
      goto(149); flash_mode = 1'b0;
      goto(152); ped_req = 3'b001;
      goto(153); ped_req = 3'b000;
      goto(156); reset_n = 1'b0;
      goto(157); reset_n = 1'b1;

      // random run under invariant checking only
      goto(166);
      for (int i = 0; i < 1000; i++) begin
         ped_req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) flash_mode = ~flash_mode;
         step();
      end
      flash_mode = 1'b0;
      ped_req    = 3'b000;
      step();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_seq_ctrl.md
# traffic_light_seq_ctrl

Parametrised N-direction traffic light sequencer. It cycles green through each approach in round-robin order, with per-phase yellow and all-red clearance intervals. It also supports latched pedestrian requests that extend green and assert a walk signal, plus a flashing-yellow fallback mode. It sits under the intersection top level, driving lamp outputs directly from the system clock domain.

## Interface
- NUM_DIR, 4: number of approaches, 2..8
- CNT_W, 16: phase counter width; must hold max duration − 1
- GREEN_T, 20: normal green duration in cycles, ≥1
- PED_GREEN_T, 32: green duration when a pedestrian request is granted, ≥ GREEN_T
- YELLOW_T, 4: yellow duration in cycles, ≥1
- ALLRED_T, 2: all-red clearance duration in cycles, ≥1
- FLASH_T, 8: half-period of flashing yellow, in cycles, ≥1
- DIR_W, derived: max(1, $clog2(NUM_DIR))

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- flash_mode  in  1  level; high selects flashing-yellow mode
- ped_req  in  NUM_DIR  level-sampled pedestrian request per approach
- red  out  NUM_DIR  red lamp per approach
- yellow  out  NUM_DIR  yellow lamp per approach
- green  out  NUM_DIR  green lamp per approach
- walk  out  NUM_DIR  pedestrian walk lamp per approach
- active_dir  out  DIR_W  approach currently owning the GREEN/YELLOW phase
- phase  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW, 3=FLASH

## Operation
- State register fields: phase, active_dir, down-counter cnt, ped_latch[NUM_DIR], ped_grant, flash_on.
- Reset (reset_n low at a clk edge) sets: phase=ALL_RED, cnt=ALLRED_T−1, active_dir=NUM_DIR−1, ped_latch=0, ped_grant=0, flash_on=0.
- Every output is defined in reset: red=all 1, yellow=0, green=0, walk=0, active_dir=NUM_DIR−1, phase=0.
- Phase entry loads cnt=T−1. The counter decrements each cycle, and the transition occurs on the cycle after cnt==0. Each phase therefore lasts exactly T cycles.
- ALL_RED → GREEN with active_dir=(active_dir+1) mod NUM_DIR. The increment wraps from NUM_DIR−1 to 0.
- GREEN → YELLOW, same direction. YELLOW → ALL_RED.
- On GREEN entry for direction d:
  - ped_grant = ped_latch[d] | ped_req[d].
  - ped_latch[d] is cleared.
  - Duration is PED_GREEN_T if ped_grant, else GREEN_T.
- ped_latch[k] is set on any cycle with ped_req[k]=1, except the GREEN-entry capture cycle for k. A request arriving during k's own green is served next round.
- Lamp decode in ALL_RED/GREEN/YELLOW:
  - Approach active_dir shows green or yellow per phase.
  - Every other approach, and all approaches in ALL_RED, show red.
  - walk[d]=1 only during GREEN of d with ped_grant.
- Lamp outputs are exactly one-hot per approach outside FLASH.
- FLASH mode:
  - flash_mode=1 sampled at any edge, in any phase, enters FLASH next cycle.
  - Entry sets cnt=FLASH_T−1 and flash_on=1.
  - flash_on toggles each time cnt hits 0, then cnt reloads.
  - Outputs: red=0, green=0, walk=0, yellow=all flash_on.
- FLASH exit: flash_mode=0 sampled in FLASH enters ALL_RED with ALLRED_T. active_dir is unchanged, so the next green is the following approach. ped_latch is preserved throughout FLASH.
- Reset has priority over flash_mode and over every in-progress phase.

## Timing
- Moore outputs are decoded from registered state, with no extra pipeline stage. Lamps change in the same cycle phase changes.
- Zero-cycle input-to-state latency for flash_mode and ped_req: sampled at edge N, effective from cycle N+1.
- After reset_n rises, the first green for approach 0 begins after exactly ALLRED_T cycles.
- Full round-robin period with no requests: NUM_DIR·(GREEN_T+YELLOW_T+ALLRED_T) cycles.
- Asserting reset_n low mid-phase: the next cycle shows the reset values.

## Structure
- Shared package traffic_pkg holds:
  - the phase encoding constants (ALL_RED=2'd0, GREEN=2'd1, YELLOW=2'd2, FLASH=2'd3);
  - the default duration constants.
- One sub-module, phase_timer, with ports load, load_val[CNT_W], done. It is a loadable down-counter with done = (cnt==0) and is instantiated once.
- The FSM, ped latches and lamp decode live in traffic_light_seq_ctrl.

## Test plan
Params for all scenarios: NUM_DIR=3, GREEN_T=5, PED_GREEN_T=8, YELLOW_T=2, ALLRED_T=1, FLASH_T=3.

1. Reset release, no requests:
   - Cycle 0 is ALL_RED with red=3'b111.
   - Cycles 1–5 show green=3'b001; cycles 6–7 yellow=3'b001; cycle 8 ALL_RED.
   - Cycle 9 starts green=3'b010. The sequence repeats every 24 cycles, wrapping active_dir 2→0.
2. One-cycle ped_req[1] pulse during green of approach 0:
   - Approach 1 green lasts 8 cycles with walk=3'b010 throughout.
   - The next round for approach 1 lasts 5 cycles with walk=0.
3. ped_req[1] held high across the GREEN entry of approach 1:
   - The current green is 8 cycles.
   - The latch re-sets, so the next round for approach 1 is also 8 cycles.
4. flash_mode=1 mid-green of approach 1:
   - Next cycle: green=0, red=0, yellow=3'b111 for 3 cycles, then 3'b000 for 3 cycles, alternating.
   - On deassertion: 1 cycle ALL_RED, then green=3'b100.
5. reset_n=0 asserted during yellow with ped_latch set:
   - Next cycle: red=3'b111, yellow=0, phase=0, latches cleared.
   - The subsequent green for approach 0 is 5 cycles.
6. Assertion check held over a 1000-cycle random ped_req/flash_mode run:
   - Outside FLASH, each approach shows exactly one lamp.
   - At most one approach is non-red.
